// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - opcodes, ID/EX control bundle bit indices and FSM states for pipe_control
package pipe_ctrl_pkg;

    localparam int CTRL_W = 13;

    localparam logic [4:0] OP_ART  = 5'd0;
    localparam logic [4:0] OP_LOG  = 5'd1;
    localparam logic [4:0] OP_JMP  = 5'd2;
    localparam logic [4:0] OP_BQE  = 5'd3;
    localparam logic [4:0] OP_BNE  = 5'd4;
    localparam logic [4:0] OP_LD   = 5'd5;
    localparam logic [4:0] OP_ST   = 5'd6;
    localparam logic [4:0] OP_CRY  = 5'd7;
    localparam logic [4:0] OP_IMM  = 5'd8;
    localparam logic [4:0] OP_CALL = 5'd9;
    localparam logic [4:0] OP_RET  = 5'd10;

    // Bit 12 is reserved so the bundle keeps its fixed 13-bit layout; it always decodes to 0.
    localparam int CB_REGDST     = 0;
    localparam int CB_REGWRITE   = 1;
    localparam int CB_ALUSRC     = 2;
    localparam int CB_MEMREAD    = 3;
    localparam int CB_MEMWRITE   = 4;
    localparam int CB_MEMTOREG   = 5;
    localparam int CB_BRANCH     = 6;
    localparam int CB_BRANCHTYPE = 7;
    localparam int CB_JUMP       = 8;
    localparam int CB_PUSH       = 9;
    localparam int CB_POP        = 10;
    localparam int CB_RET        = 11;
    localparam int CB_RSVD       = 12;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        CALL2 = 2'd1,
        RET2  = 2'd2
    } state_e;

    function automatic logic [CTRL_W-1:0] cb(input int idx);
        return {{(CTRL_W-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// rtl/ctrl_decode.sv - combinational opcode to ID/EX control bundle decoder
module ctrl_decode
    import pipe_ctrl_pkg::*;
#(
    parameter int OPW = 5
) (
    input  logic [OPW-1:0]    opcode_i,
    output logic [CTRL_W-1:0] ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        case (opcode_i)
            OPW'(OP_ART),
            OPW'(OP_LOG):  ctrl_o = cb(CB_REGDST) | cb(CB_REGWRITE);
            OPW'(OP_JMP):  ctrl_o = cb(CB_JUMP);
            OPW'(OP_BQE):  ctrl_o = cb(CB_BRANCH);
            OPW'(OP_BNE):  ctrl_o = cb(CB_BRANCH) | cb(CB_BRANCHTYPE);
            OPW'(OP_LD):   ctrl_o = cb(CB_MEMREAD) | cb(CB_MEMTOREG) | cb(CB_REGWRITE) | cb(CB_ALUSRC);
            OPW'(OP_ST):   ctrl_o = cb(CB_MEMWRITE) | cb(CB_ALUSRC);
            OPW'(OP_CRY):  ctrl_o = cb(CB_REGWRITE);
            OPW'(OP_IMM):  ctrl_o = cb(CB_REGWRITE) | cb(CB_ALUSRC);
            OPW'(OP_CALL): ctrl_o = cb(CB_PUSH);
            OPW'(OP_RET):  ctrl_o = cb(CB_POP);
            default:       ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/pipe_control.sv
// rtl/pipe_control.sv - ID stage control: decode register, CALL/RET sequencer, optional call-depth tracking (CTRL_STACK_CHECK_EN)
module pipe_control
    import pipe_ctrl_pkg::*;
#(
    parameter int OPW   = 5,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [OPW-1:0]             opcode_i,
    input  logic                       valid_i,
    input  logic                       hazard_i,
    input  logic                       flush_i,
    output logic [CTRL_W-1:0]          ctrl_o,
    output logic                       ctrl_valid_o,
    output logic                       stall_o,
    output logic [$clog2(DEPTH+1)-1:0] depth_o,
    output logic                       stack_ovf_o,
    output logic                       stack_unf_o
);

    localparam int DW = $clog2(DEPTH+1);

    state_e              state_q, state_d;
    logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
    logic                cvalid_q, cvalid_d;
    logic [CTRL_W-1:0]   dec_ctrl;

    ctrl_decode #(.OPW(OPW)) u_decode (
        .opcode_i (opcode_i),
        .ctrl_o   (dec_ctrl)
    );

    always_comb begin
        state_d  = state_q;
        ctrl_d   = '0;
        cvalid_d = 1'b0;
        if (flush_i) begin
            state_d = RUN;
        end else if (!hazard_i) begin
            case (state_q)
                RUN: begin
                    if (valid_i) begin
                        ctrl_d   = dec_ctrl;
                        cvalid_d = 1'b1;
                        if (dec_ctrl[CB_PUSH])
                            state_d = CALL2;
                        else if (dec_ctrl[CB_POP])
                            state_d = RET2;
                    end
                end
                CALL2: begin
                    ctrl_d   = cb(CB_JUMP);
                    cvalid_d = 1'b1;
                    state_d  = RUN;
                end
                RET2: begin
                    ctrl_d   = cb(CB_RET);
                    cvalid_d = 1'b1;
                    state_d  = RUN;
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= RUN;
            ctrl_q   <= '0;
            cvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ctrl_q   <= ctrl_d;
            cvalid_q <= cvalid_d;
        end
    end

    assign ctrl_o       = ctrl_q;
    assign ctrl_valid_o = cvalid_q;
    assign stall_o      = !rst && ((state_q != RUN) || hazard_i);

`ifdef CTRL_STACK_CHECK_EN
    // push/pop bits of ctrl_d are only ever set when a CALL/RET is actually accepted.
    logic [DW-1:0] depth_q, depth_d;
    logic          ovf_q, ovf_d, unf_q, unf_d;

    always_comb begin
        depth_d = depth_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        if (ctrl_d[CB_PUSH]) begin
            if (depth_q == DW'(DEPTH))
                ovf_d = 1'b1;
            else
                depth_d = depth_q + 1'b1;
        end else if (ctrl_d[CB_POP]) begin
            if (depth_q == '0)
                unf_d = 1'b1;
            else
                depth_d = depth_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            depth_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            depth_q <= depth_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign depth_o     = depth_q;
    assign stack_ovf_o = ovf_q;
    assign stack_unf_o = unf_q;
`else
    assign depth_o     = '0;
    assign stack_ovf_o = 1'b0;
    assign stack_unf_o = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_control.sv
// tb/tb_pipe_control.sv - self-checking bench for pipe_control (DEPTH=2), follows CTRL_STACK_CHECK_EN
module tb_pipe_control;
    import pipe_ctrl_pkg::*;

    localparam int TB_DEPTH = 2;
`ifdef CTRL_STACK_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  opcode;
    logic        valid, hazard, flush;
    logic [12:0] ctrl;
    logic        ctrl_valid, stall, ovf, unf;
    logic [1:0]  depth;

    int n_cmp = 0;
    int n_bad = 0;

    pipe_control #(.OPW(5), .DEPTH(TB_DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .opcode_i     (opcode),
        .valid_i      (valid),
        .hazard_i     (hazard),
        .flush_i      (flush),
        .ctrl_o       (ctrl),
        .ctrl_valid_o (ctrl_valid),
        .stall_o      (stall),
        .depth_o      (depth),
        .stack_ovf_o  (ovf),
        .stack_unf_o  (unf)
    );

    always #5 clk = ~clk;

    function automatic logic [12:0] bm(input int i);
        logic [12:0] one;
        one = 13'd1;
        return one << i;
    endfunction

    function automatic logic [12:0] exp_dec(input logic [4:0] op);
        if (op == OP_ART || op == OP_LOG) return bm(CB_REGDST) | bm(CB_REGWRITE);
        if (op == OP_JMP)  return bm(CB_JUMP);
        if (op == OP_BQE)  return bm(CB_BRANCH);
        if (op == OP_BNE)  return bm(CB_BRANCH) | bm(CB_BRANCHTYPE);
        if (op == OP_LD)   return bm(CB_MEMREAD) | bm(CB_MEMTOREG) | bm(CB_REGWRITE) | bm(CB_ALUSRC);
        if (op == OP_ST)   return bm(CB_MEMWRITE) | bm(CB_ALUSRC);
        if (op == OP_CRY)  return bm(CB_REGWRITE);
        if (op == OP_IMM)  return bm(CB_REGWRITE) | bm(CB_ALUSRC);
        if (op == OP_CALL) return bm(CB_PUSH);
        if (op == OP_RET)  return bm(CB_POP);
        return 13'd0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // drive inputs just after an edge, then advance one clock and settle
    task automatic drive(input logic [4:0] op, input logic v, input logic hz, input logic fl);
        opcode = op; valid = v; hazard = hz; flush = fl;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(5'd0, 1'b0, 1'b1, 1'b0);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        drive(5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // Reference model: a pending "second half" word plus an integer depth.
    bit          m_pend;
    logic [12:0] m_pend_word;
    int          m_depth;
    bit          m_ovf, m_unf, m_val;
    logic [12:0] m_ctrl;

    task automatic model_reset();
        m_pend = 0; m_pend_word = '0; m_depth = 0;
        m_ovf = 0; m_unf = 0; m_val = 0; m_ctrl = '0;
    endtask

    task automatic model_edge(input logic [4:0] op, input bit v, input bit hz, input bit fl);
        if (fl) begin
            m_ctrl = '0; m_val = 0; m_pend = 0;
        end else if (hz) begin
            m_ctrl = '0; m_val = 0;
        end else if (m_pend) begin
            m_ctrl = m_pend_word; m_val = 1; m_pend = 0;
        end else if (v) begin
            m_ctrl = exp_dec(op); m_val = 1;
            if (op == OP_CALL) begin
                m_pend = 1; m_pend_word = bm(CB_JUMP);
                if (m_depth == TB_DEPTH) m_ovf = 1; else m_depth = m_depth + 1;
            end else if (op == OP_RET) begin
                m_pend = 1; m_pend_word = bm(CB_RET);
                if (m_depth == 0) m_unf = 1; else m_depth = m_depth - 1;
            end
        end else begin
            m_ctrl = '0; m_val = 0;
        end
    endtask

    typedef struct {
        logic [4:0]  op;
        logic        v, hz, fl;
        logic [12:0] ectl;
        logic        ev;
    } vec_t;

    vec_t tbl[$];

    initial begin
        tbl.push_back('{OP_ART, 1, 0, 0, bm(CB_REGDST) | bm(CB_REGWRITE), 1});
        tbl.push_back('{OP_LOG, 1, 0, 0, bm(CB_REGDST) | bm(CB_REGWRITE), 1});
        tbl.push_back('{OP_JMP, 1, 0, 0, bm(CB_JUMP), 1});
        tbl.push_back('{OP_BQE, 1, 0, 0, bm(CB_BRANCH), 1});
        tbl.push_back('{OP_BNE, 1, 0, 0, bm(CB_BRANCH) | bm(CB_BRANCHTYPE), 1});
        tbl.push_back('{OP_LD,  1, 0, 0, 13'h002e, 1});
        tbl.push_back('{OP_ST,  1, 0, 0, bm(CB_MEMWRITE) | bm(CB_ALUSRC), 1});
        tbl.push_back('{OP_CRY, 1, 0, 0, bm(CB_REGWRITE), 1});
        tbl.push_back('{OP_IMM, 1, 0, 0, bm(CB_REGWRITE) | bm(CB_ALUSRC), 1});
        tbl.push_back('{5'd11,  1, 0, 0, 13'd0, 1});
        tbl.push_back('{5'd31,  1, 0, 0, 13'd0, 1});
        tbl.push_back('{OP_LD,  0, 0, 0, 13'd0, 0});
        tbl.push_back('{OP_ST,  1, 1, 0, 13'd0, 0});
        tbl.push_back('{OP_IMM, 1, 0, 1, 13'd0, 0});
        tbl.push_back('{OP_CALL,1, 1, 1, 13'd0, 0});

        rst = 1'b1;
        drive(5'd0, 1'b0, 1'b1, 1'b0);
        #2;
        chk("reset_ctrl", 32'(ctrl), 32'd0);
        chk("reset_valid", 32'(ctrl_valid), 32'd0);
        chk("reset_stall", 32'(stall), 32'd0);
        chk("reset_depth", 32'(depth), 32'd0);
        chk("reset_flags", {30'd0, ovf, unf}, 32'd0);
        do_reset();

        // single-cycle decode table (all rows leave the FSM in RUN)
        foreach (tbl[i]) begin
            drive(tbl[i].op, tbl[i].v, tbl[i].hz, tbl[i].fl);
            chk($sformatf("tbl%0d_stall", i), 32'(stall), 32'(tbl[i].hz));
            tick();
            chk($sformatf("tbl%0d_ctrl", i), 32'(ctrl), 32'(tbl[i].ectl));
            chk($sformatf("tbl%0d_valid", i), 32'(ctrl_valid), 32'(tbl[i].ev));
        end

        // CALL two-cycle sequence
        do_reset();
        drive(OP_CALL, 1, 0, 0);
        tick();
        chk("call_push", 32'(ctrl), 32'(bm(CB_PUSH)));
        chk("call_depth1", 32'(depth), CHK ? 32'd1 : 32'd0);
        drive(OP_LD, 1, 0, 0);
        chk("call2_stall", 32'(stall), 32'd1);
        tick();
        chk("call_jump", 32'(ctrl), 32'(bm(CB_JUMP)));
        chk("call_jump_valid", 32'(ctrl_valid), 32'd1);
        drive(OP_LD, 0, 0, 0);
        chk("call_back_run", 32'(stall), 32'd0);

        // hazard held over CALL2
        do_reset();
        drive(OP_CALL, 1, 0, 0);
        tick();
        for (int k = 0; k < 2; k++) begin
            drive(OP_ST, 1, 1, 0);
            chk($sformatf("callhz%0d_stall", k), 32'(stall), 32'd1);
            tick();
            chk($sformatf("callhz%0d_ctrl", k), 32'(ctrl), 32'd0);
            chk($sformatf("callhz%0d_valid", k), 32'(ctrl_valid), 32'd0);
        end
        drive(OP_ST, 1, 0, 0);
        chk("callhz_stall_after", 32'(stall), 32'd1);
        tick();
        chk("callhz_jump", 32'(ctrl), 32'(bm(CB_JUMP)));
        chk("callhz_depth", 32'(depth), CHK ? 32'd1 : 32'd0);

        // depth saturation at DEPTH, then underflow from empty
        do_reset();
        for (int k = 0; k < 3; k++) begin
            drive(OP_CALL, 1, 0, 0);
            tick();
            chk($sformatf("sat%0d_push", k), 32'(ctrl), 32'(bm(CB_PUSH)));
            chk($sformatf("sat%0d_ovf", k), 32'(ovf), (CHK && k == 2) ? 32'd1 : 32'd0);
            drive(OP_CALL, 0, 0, 0);
            tick();
        end
        chk("sat_depth", 32'(depth), CHK ? 32'd2 : 32'd0);
        do_reset();
        for (int k = 0; k < 3; k++) begin
            drive(OP_RET, 1, 0, 0);
            tick();
            chk($sformatf("unf%0d_pop", k), 32'(ctrl), 32'(bm(CB_POP)));
            drive(OP_RET, 0, 0, 0);
            tick();
            chk($sformatf("unf%0d_ret", k), 32'(ctrl), 32'(bm(CB_RET)));
        end
        chk("unf_flag", 32'(unf), CHK ? 32'd1 : 32'd0);
        chk("unf_depth", 32'(depth), 32'd0);
        chk("unf_ovf_clear", 32'(ovf), 32'd0);

        // flush + hazard together during RET2
        do_reset();
        for (int k = 0; k < 2; k++) begin
            drive(OP_CALL, 1, 0, 0); tick();
            drive(OP_CALL, 0, 0, 0); tick();
        end
        drive(OP_RET, 1, 0, 0);
        tick();
        chk("fl_pop_depth", 32'(depth), CHK ? 32'd1 : 32'd0);
        drive(OP_RET, 1, 1, 1);
        tick();
        chk("fl_ctrl", 32'(ctrl), 32'd0);
        chk("fl_valid", 32'(ctrl_valid), 32'd0);
        chk("fl_depth", 32'(depth), CHK ? 32'd1 : 32'd0);
        drive(OP_LD, 1, 0, 0);
        chk("fl_run_stall", 32'(stall), 32'd0);
        tick();
        chk("fl_run_ld", 32'(ctrl), 32'h002e);

        // async reset in the middle of a CALL
        do_reset();
        drive(OP_CALL, 1, 0, 0);
        tick();
        drive(OP_CALL, 0, 1, 0);
        rst = 1'b1;
        #1;
        chk("midrst_ctrl", 32'(ctrl), 32'd0);
        chk("midrst_stall", 32'(stall), 32'd0);
        chk("midrst_depth", 32'(depth), 32'd0);
        tick();
        rst = 1'b0;
        drive(OP_IMM, 1, 0, 0);
        chk("midrst_run", 32'(stall), 32'd0);
        tick();
        chk("midrst_imm", 32'(ctrl), 32'(bm(CB_REGWRITE) | bm(CB_ALUSRC)));

        // randomized run against the reference model
        do_reset();
        model_reset();
        for (int c = 0; c < 400; c++) begin
            logic [4:0] op;
            logic v, hz, fl;
            op = 5'($urandom_range(0, 15));
            v  = ($urandom_range(0, 3) != 0);
            hz = ($urandom_range(0, 4) == 0);
            fl = ($urandom_range(0, 7) == 0);
            drive(op, v, hz, fl);
            chk($sformatf("rnd%0d_stall", c), 32'(stall), 32'(m_pend || hz));
            model_edge(op, v, hz, fl);
            tick();
            chk($sformatf("rnd%0d_ctrl", c), 32'(ctrl), 32'(m_ctrl));
            chk($sformatf("rnd%0d_valid", c), 32'(ctrl_valid), 32'(m_val));
            chk($sformatf("rnd%0d_depth", c), 32'(depth), CHK ? 32'(m_depth) : 32'd0);
            chk($sformatf("rnd%0d_flags", c), {30'd0, ovf, unf}, CHK ? {30'd0, m_ovf, m_unf} : 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipe_control.md
PIPE_CONTROL -- requirements
Module: pipe_control

Interface
REQ-001 Parameter OPW, default 5: opcode width; must be >= 5.
REQ-002 Parameter DEPTH, default 8: call-stack depth tracked by the depth counter; must be >= 1.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 opcode_i  input  OPW  instruction opcode from IF/ID.
REQ-006 valid_i  input  1  opcode_i holds a real instruction.
REQ-007 hazard_i  input  1  load-use hazard: insert a bubble and hold state.
REQ-008 flush_i  input  1  taken branch or jump: kill the in-flight decode.
REQ-009 ctrl_o  output  13  registered ID/EX control bundle; bit order is fixed by the package.
REQ-010 ctrl_valid_o  output  1  ctrl_o carries a real instruction.
REQ-011 stall_o  output  1  upstream must hold IF/ID this cycle.
REQ-012 depth_o  output  $clog2(DEPTH+1)  current call depth.
REQ-013 stack_ovf_o  output  1  sticky flag: push attempted while depth_o == DEPTH.
REQ-014 stack_unf_o  output  1  sticky flag: pop attempted while depth_o == 0.

Function
REQ-015 Decode is combinational; ctrl_o and ctrl_valid_o register it, so an opcode accepted in cycle N appears on ctrl_o in cycle N+1.
REQ-016 Decode table: ART/LOG -> regdist+regwrite; JMP -> jump; BQE -> branch; BNE -> branch+branchtype; LD -> memread+memtoreg+regwrite+alusrc; ST -> memwrite+alusrc; CRY -> regwrite; IMM -> regwrite+alusrc; any other opcode -> all zero with ctrl_valid_o = 1.
REQ-017 FSM states: RUN, CALL2, RET2.
REQ-018 CALL is two cycles:
- RUN + CALL -> ctrl_o = push only, depth increments, next state CALL2.
- CALL2 -> ctrl_o = jump only, next state RUN.
REQ-019 RET is two cycles:
- RUN + RET -> ctrl_o = pop only, depth decrements, next state RET2.
- RET2 -> ctrl_o = ret only, next state RUN.
REQ-020 stall_o = 1 combinationally whenever state is CALL2 or RET2, or hazard_i = 1.
REQ-021 Priority: rst > flush_i > hazard_i > normal operation.
REQ-022 flush_i = 1: next ctrl_o = 0, ctrl_valid_o = 0, state -> RUN; a depth change already committed is not undone.
REQ-023 hazard_i = 1 (no flush): next ctrl_o = 0, ctrl_valid_o = 0; state and depth hold; the second cycle of CALL/RET is issued after the hazard clears.
REQ-024 valid_i = 0 in RUN: bubble (ctrl_o = 0, ctrl_valid_o = 0).
REQ-025 Depth counter saturates at both ends:
- Push at DEPTH: depth holds, stack_ovf_o set.
- Pop at 0: depth holds, stack_unf_o set.
- push/pop bits are still emitted in both cases.
REQ-026 stack_ovf_o and stack_unf_o clear only on reset.

Reset
REQ-027 rst = 1 asynchronously forces: state RUN, ctrl_o = 0, ctrl_valid_o = 0, depth_o = 0, both flags 0.
REQ-028 stall_o = 0 while in reset.
REQ-029 Reset asserted mid-CALL/RET abandons the operation.

Configuration
REQ-030 Macro CTRL_STACK_CHECK_EN defined: depth counter and overflow/underflow flags are implemented per REQ-025/026.
REQ-031 Macro undefined: depth_o, stack_ovf_o and stack_unf_o are tied to 0 and no counter is synthesised; all other behaviour is unchanged.

Structure
REQ-032 Shared package pipe_ctrl_pkg holds:
- opcode localparams (ART…IMM, CALL, RET);
- the 13-bit ctrl bundle field index constants;
- the FSM state enum.
REQ-033 The combinational decoder is sub-module ctrl_decode (opcode in, bundle out); pipe_control wraps it with the FSM and registers.

Verification
REQ-034 Reset, then LD with valid_i = 1 at cycle 0 -> cycle 1: ctrl_o = memread|memtoreg|regwrite|alusrc, ctrl_valid_o = 1, stall_o = 0.
REQ-035 CALL at cycle 0 -> cycle 1: ctrl_o = push, depth_o = 1, stall_o = 1; cycle 2: ctrl_o = jump, state RUN.
REQ-036 CALL accepted, then hazard_i = 1 for 2 cycles during CALL2 -> two bubbles, stall_o = 1 throughout, then jump issued, depth_o stays 1.
REQ-037 DEPTH = 2, three CALLs -> depth_o = 2, stack_ovf_o = 1 after the third push; then RET ×3 from reset depth 0 path -> stack_unf_o = 1.
REQ-038 Simultaneous flush_i and hazard_i during RET2 -> next ctrl_o = 0, state RUN, depth keeps the decremented value.
REQ-039 With CTRL_STACK_CHECK_EN undefined, repeat REQ-037 -> depth_o and both flags remain 0.
